// File: rtl/onehot_request_encoder_pkg.sv
// Shared definitions for the request encoder and the round-robin arbiters
// in the controller.
package onehot_request_encoder_pkg;

  localparam int REQ_W    = 4;
  localparam int RR_MAX_N = 32;

  // Returns the first set bit of vec[n-1:0] at or above start, wrapping n-1 -> 0.
  // Returns -1 when no bit is set. Assumes start < n <= RR_MAX_N.
  function automatic int rr_first_set(input logic [RR_MAX_N-1:0] vec,
                                      input int start,
                                      input int n);
    int idx;
    int j;
    idx = -1;
    for (int i = 0; i < RR_MAX_N; i++) begin
      if (i < n && idx < 0) begin
        j = start + i;
        if (j >= n) j = j - n;
        if (vec[j]) idx = j;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_request_encoder_rr_priority_select.sv
// Combinational round-robin first-set selector; shared by the controller arbiters.
module rr_priority_select
  import onehot_request_encoder_pkg::*;
#(
  parameter int N = REQ_W,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_vector,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_index,
  output logic         o_found
);

  int w_idx;

  always_comb begin
    w_idx = rr_first_set(RR_MAX_N'(i_vector), int'(i_ptr), N);
  end

  assign o_found = (w_idx >= 0);
  assign o_index = o_found ? W'(w_idx) : '0;

endmodule

// File: rtl/onehot_request_encoder.sv
// Sticky multi-hot request capture with round-robin encoding onto a
// valid/ready index stream toward the control-memory sequencer.
//
//   state    | meaning
//   ST_EMPTY | no index presented (code_valid = 0)
//   ST_HOLD  | index presented in code, waiting for code_ready
module onehot_request_encoder
  import onehot_request_encoder_pkg::*;
#(
  parameter int N = REQ_W,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic         code_valid,
  output logic [W-1:0] code,
  input  logic         code_ready,
  output logic [N-1:0] pending,
  output logic         busy
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_pend;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_code;

  logic [W-1:0] w_sel_idx;
  logic         w_sel_found;
  logic         w_load;
  logic [N-1:0] w_clr;
  logic [W-1:0] w_ptr_nxt;

  rr_priority_select #(.N(N), .W(W)) u_sel (
    .i_vector (r_pend),
    .i_ptr    (r_ptr),
    .o_index  (w_sel_idx),
    .o_found  (w_sel_found)
  );

  // Selection sees only the registered pend; new strobes wait one edge.
  assign w_load    = enable && w_sel_found && ((r_state == ST_EMPTY) || code_ready);
  assign w_clr     = w_load ? ({{(N-1){1'b0}}, 1'b1} << w_sel_idx) : '0;
  assign w_ptr_nxt = (w_sel_idx == W'(N-1)) ? '0 : w_sel_idx + W'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_load) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (code_ready) w_state_nxt = w_load ? ST_HOLD : ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_pend  <= '0;
      r_ptr   <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Set wins over clear: a strobe on the granted bit re-arms it.
      r_pend  <= (r_pend & ~w_clr) | req;
      if (w_load) begin
        r_ptr  <= w_ptr_nxt;
        r_code <= w_sel_idx;
      end
    end
  end

  assign code_valid = (r_state == ST_HOLD);
  assign code       = r_code;
  assign pending    = r_pend;
  assign busy       = (|r_pend) || code_valid;

endmodule

// File: tb/tb_onehot_request_encoder.sv
// Directed-vector bench for onehot_request_encoder (N=4).
module tb_onehot_request_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       enable = 1'b1;
  logic       code_valid;
  logic [1:0] code;
  logic       code_ready = 1'b1;
  logic [3:0] pending;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  onehot_request_encoder #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .enable     (enable),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (code_ready),
    .pending    (pending),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0;
    enable = 1'b1;
    code_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check_val("rst_valid", 32'(code_valid), 32'd0);
    check_val("rst_code", 32'(code), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    do_reset();

    // Single pulse on bit 2
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check_val("single_pend", 32'(pending), 32'h4);
    check_val("single_novalid", 32'(code_valid), 32'd0);
    tick();
    check_val("single_valid", 32'(code_valid), 32'd1);
    check_val("single_code", 32'(code), 32'd2);
    check_val("single_pend_clr", 32'(pending), 32'h0);
    tick();
    check_val("single_drop", 32'(code_valid), 32'd0);
    check_val("single_ptr", 32'(dut.r_ptr), 32'd3);

    // Round-robin fairness from ptr=0
    do_reset();
    req = 4'b1111;
    tick();
    req = 4'b0000;
    check_val("rr_pend", 32'(pending), 32'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("rr_valid", 32'(code_valid), 32'd1);
      check_val("rr_code", 32'(code), 32'(i));
    end
    tick();
    check_val("rr_end_valid", 32'(code_valid), 32'd0);
    check_val("rr_end_busy", 32'(busy), 32'd0);

    // Backpressure (ptr back at 0)
    code_ready = 1'b0;
    req = 4'b0011;
    tick();
    req = 4'b0000;
    tick();
    check_val("bp_load", 32'(code), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_stall_valid", 32'(code_valid), 32'd1);
      check_val("bp_stall_code", 32'(code), 32'd0);
    end
    check_val("bp_stall_pend", 32'(pending), 32'h2);
    code_ready = 1'b1;
    tick();
    check_val("bp_next_valid", 32'(code_valid), 32'd1);
    check_val("bp_next_code", 32'(code), 32'd1);
    tick();
    check_val("bp_done", 32'(code_valid), 32'd0);

    // Set-wins collision on bit 1 (ptr=2)
    req = 4'b0010;
    tick();
    check_val("col_pend", 32'(pending), 32'h2);
    tick();
    req = 4'b0000;
    check_val("col_first_code", 32'(code), 32'd1);
    check_val("col_pend_kept", 32'(pending), 32'h2);
    tick();
    check_val("col_second_valid", 32'(code_valid), 32'd1);
    check_val("col_second_code", 32'(code), 32'd1);
    check_val("col_pend_empty", 32'(pending), 32'h0);
    tick();
    check_val("col_done", 32'(code_valid), 32'd0);

    // enable gating
    enable = 1'b0;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("en_novalid", 32'(code_valid), 32'd0);
      check_val("en_busy", 32'(busy), 32'd1);
    end
    check_val("en_pend", 32'(pending), 32'h8);
    enable = 1'b1;
    tick();
    check_val("en_valid", 32'(code_valid), 32'd1);
    check_val("en_code", 32'(code), 32'd3);
    tick();

    // Mid-operation async reset (ptr=0)
    code_ready = 1'b0;
    req = 4'b0111;
    tick();
    req = 4'b0000;
    tick();
    check_val("mr_pre_valid", 32'(code_valid), 32'd1);
    check_val("mr_pre_pend", 32'(pending), 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mr_valid", 32'(code_valid), 32'd0);
    check_val("mr_code", 32'(code), 32'd0);
    check_val("mr_pend", 32'(pending), 32'd0);
    check_val("mr_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    code_ready = 1'b1;
    req = 4'b1010;
    tick();
    req = 4'b0000;
    tick();
    check_val("mr_first_valid", 32'(code_valid), 32'd1);
    check_val("mr_first_code", 32'(code), 32'd1);
    tick();
    check_val("mr_second_code", 32'(code), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
